// File: rtl/data_mem_resp_if.sv
// Core-side load/store request and response bus for data_mem_resp.
interface data_mem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Core side drives requests and accepts responses
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Memory side accepts requests and drives responses
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_resp.sv
// Single-port data memory with valid/ready request and response channels,
// a fixed number of wait states, RISC-V byte/half/word load-store decode.
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag misaligned
// halfword/word accesses as errors instead of silently aligning them.
module data_mem_resp #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    data_mem_resp_if.slave     bus
);

    localparam int unsigned WORDS   = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned UNUSE_W = 32 - DEPTH_LOG2 - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_c;
    logic               enter_resp_c;
    logic               rsp_done_c;

    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [2:0]         func3_q;

    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    logic [31:0]        mem [WORDS];

    // Operand view: live bus in IDLE (zero-wait accept), captured copy otherwise
    logic               op_we_c;
    logic [31:0]        op_addr_c;
    logic [31:0]        op_wdata_c;
    logic [2:0]         op_func3_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic [UNUSE_W-1:0] addr_unused;

    logic [31:0]        word_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        load_c;
    logic [31:0]        store_mask_c;
    logic [31:0]        store_data_c;
    logic [31:0]        store_word_c;
    logic               illegal_c;
    logic               misalign_c;
    logic               err_c;

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter and strobe decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept_c     = 1'b0;
        enter_resp_c = 1'b0;
        rsp_done_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_c = 1'b1;
                    cnt_d    = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d      = RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = RESP;
                    enter_resp_c = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d    = IDLE;
                    rsp_done_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the operands the access is computed from
    always_comb begin
        if (state_q == IDLE) begin
            op_we_c    = bus.req_we;
            op_addr_c  = bus.req_addr;
            op_wdata_c = bus.req_wdata;
            op_func3_c = bus.req_func3;
        end else begin
            op_we_c    = we_q;
            op_addr_c  = addr_q;
            op_wdata_c = wdata_q;
            op_func3_c = func3_q;
        end
    end

    // High address bits are deliberately dropped so accesses wrap
    assign idx_c       = op_addr_c[DEPTH_LOG2+1:2];
    assign addr_unused = op_addr_c[31:DEPTH_LOG2+2];
    assign word_c      = mem[idx_c];
    assign byte_c      = 8'(word_c >> {op_addr_c[1:0], 3'b000});
    assign half_c      = op_addr_c[1] ? word_c[31:16] : word_c[15:0];

    // Load extraction, store lane merge and legality
    always_comb begin
        load_c       = '0;
        store_mask_c = '0;
        store_data_c = '0;
        illegal_c    = 1'b0;
        if (op_we_c) begin
            case (op_func3_c)
                3'b000: begin
                    store_mask_c = 32'h0000_00FF << {op_addr_c[1:0], 3'b000};
                    store_data_c = {4{op_wdata_c[7:0]}};
                end
                3'b001: begin
                    store_mask_c = op_addr_c[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                    store_data_c = {2{op_wdata_c[15:0]}};
                end
                3'b010: begin
                    store_mask_c = 32'hFFFF_FFFF;
                    store_data_c = op_wdata_c;
                end
                default: illegal_c = 1'b1;
            endcase
        end else begin
            case (op_func3_c)
                3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
                3'b001:  load_c = {{16{half_c[15]}}, half_c};
                3'b010:  load_c = word_c;
                3'b100:  load_c = {24'h0, byte_c};
                3'b101:  load_c = {16'h0, half_c};
                default: illegal_c = 1'b1;
            endcase
        end
    end

    assign store_word_c = (word_c & ~store_mask_c) | (store_data_c & store_mask_c);

`ifdef DMEM_MISALIGN_CHECK_EN
    // Halfwords need addr[0]=0, words need addr[1:0]=0
    assign misalign_c = ((op_func3_c[1:0] == 2'b01) && op_addr_c[0]) ||
                        ((op_func3_c[1:0] == 2'b10) && (op_addr_c[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    assign err_c = illegal_c || misalign_c;

    // Memory array: written once on the edge entering RESP, never reset
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp_c && op_we_c && !err_c) begin
            mem[idx_c] <= store_word_c;
        end
    end

    // Request capture and registered response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            func3_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                func3_q <= bus.req_func3;
            end
            if (enter_resp_c) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_c;
                rsp_rdata_q <= (op_we_c || err_c) ? 32'h0 : load_c;
            end else if (rsp_done_c) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end
            req_ready_q <= (state_d == IDLE);
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed vector table, reset and
// back-pressure sequences, then random traffic against a byte-array model.
module tb_data_mem_resp;

    localparam int unsigned DEPTH_LOG2  = 8;
    localparam int unsigned WAIT_CYCLES = 1;
    localparam int unsigned BYTES       = 4 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mb [BYTES];

    data_mem_resp_if bus ();

    data_mem_resp #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endfunction

    // Reference: little-endian byte memory, address taken modulo its size
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, output logic [31:0] rd, output logic e);
        int unsigned a, size, base;
        logic [31:0] val;
        logic legal;
        a    = addr % BYTES;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        e = !legal;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (a % size != 0) e = 1'b1;
`endif
        base = a - (a % size);
        rd   = 32'h0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < int'(size); i++) mb[base + i] = 8'(wdata >> (8 * i));
        end else begin
            val = 32'h0;
            for (int i = 0; i < int'(size); i++) val |= 32'(mb[base + i]) << (8 * i);
            if (!f3[2] && size < 4 && val[8 * size - 1]) val |= ~((32'h1 << (8 * size)) - 32'h1);
            rd = val;
        end
    endtask

    // One full transaction from the core side; poke drives a stray request during RESP
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int hold, input bit poke,
                        output logic [31:0] rdata, output logic err);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_func3 = f3;
        bus.rsp_ready = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'(bus.req_ready), 32'h1);
            bus.req_valid = 1'b0;
            rdata = 'x;
            err   = 1'bx;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 32'(n), 32'(WAIT_CYCLES + 1));
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_addr  = 32'h30;
                bus.req_wdata = 32'hBADBAD00;
                bus.req_func3 = 3'b010;
            end
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'h1);
            chk("hold_rdata", bus.rsp_rdata, rdata);
            chk("hold_err", 32'(bus.rsp_err), 32'(err));
            chk("hold_req_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("post_req_ready", 32'(bus.req_ready), 32'h1);
    endtask

    // Run one access through DUT and model and compare the response
    task automatic run_model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3, input int hold, input string nm);
        logic [31:0] rd, mrd;
        logic e, me;
        xact(we, addr, wdata, f3, hold, 1'b0, rd, e);
        model_access(we, addr, wdata, f3, mrd, me);
        chk({nm, "_rdata"}, rd, mrd);
        chk({nm, "_err"}, 32'(e), 32'(me));
    endtask

    initial begin
        logic [31:0] rd, mrd;
        logic e, me;

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_func3 = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill every word so all later loads have defined contents
        for (int i = 0; i < (1 << DEPTH_LOG2); i++)
            run_model(1'b1, 32'(i * 4), $urandom, 3'b010, 0, "prefill");

        // Directed vectors
        vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h11,  32'h00000080, 3'b000, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h11,  32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 32'h11,  32'h0,        3'b100, 32'h00000080, 1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b010, 32'hDEAD80EF, 1'b0});
        vecs.push_back('{1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b101, 32'h000080EF, 1'b0});
`ifdef DMEM_MISALIGN_CHECK_EN
        vecs.push_back('{1'b0, 32'h12,  32'h0,        3'b010, 32'h0,        1'b1});
`else
        vecs.push_back('{1'b0, 32'h12,  32'h0,        3'b010, 32'hDEAD80EF, 1'b0});
`endif
        vecs.push_back('{1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h400, 32'h00000001, 3'b010, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   32'h0,        3'b010, 32'h00000001, 1'b0});
        vecs.push_back('{1'b1, 32'h2,   32'hABCD1234, 3'b001, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   32'h0,        3'b010, 32'h12340001, 1'b0});
        vecs.push_back('{1'b1, 32'h0,   32'hFFFFFFFF, 3'b100, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0,   32'h0,        3'b010, 32'h12340001, 1'b0});
        vecs.push_back('{1'b0, 32'h3,   32'h0,        3'b000, 32'h00000012, 1'b0});
        vecs.push_back('{1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 1'b0});
        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, 0, 1'b0, rd, e);
            model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, mrd, me);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
        end

        // Reset in WAIT aborts the store to 0x20
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h12345678;
        bus.req_func3 = 3'b010;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("wait_rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("wait_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("wait_rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("wait_rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        run_model(1'b0, 32'h20, 32'h0, 3'b010, 0, "wait_rst_lw");

        // Back-pressure in RESP with a stray request that must be ignored
        xact(1'b0, 32'h10, 32'h0, 3'b010, 5, 1'b1, rd, e);
        model_access(1'b0, 32'h10, 32'h0, 3'b010, mrd, me);
        chk("hold_lw_rdata", rd, mrd);
        chk("hold_lw_err", 32'(e), 32'(me));
        run_model(1'b0, 32'h30, 32'h0, 3'b010, 0, "stray_store");

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            run_model(1'($urandom_range(0, 1)), $urandom, $urandom,
                      3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
